// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in serial-out serializer.
// State encoding and default word width.
package piso_pkg;

    localparam int PISO_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } piso_state_e;

endpackage

// File: rtl/piso_bit_counter.sv
// Bit position counter for the serializer: synchronous clear, enable,
// and a terminal flag at WIDTH-1. Saturates at WIDTH-1 so it never wraps inside a word.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_WIDTH_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LAST_IDX)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == LAST_IDX);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out converter, MSB first, with valid/ready on the serial side.
// Optional trailing even-parity bit when PISO_PARITY_EN is defined.
//
//   state  | meaning
//   IDLE   | load_ready high, waiting for load_valid
//   SHIFT  | shift register MSB on sout, one bit per ser_ready edge
//   PARITY | even parity of the captured word on sout (PISO_PARITY_EN only)
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             ser_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             done
);

    piso_state_e      state_q;
    piso_state_e      state_d;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic             done_q;
    logic             done_d;
    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_last;
`ifdef PISO_PARITY_EN
    logic             par_q;
    logic             par_d;
`endif

    piso_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .last    (cnt_last)
    );

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        done_d  = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
`ifdef PISO_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    sr_d    = d;
                    cnt_clr = 1'b1;
                    state_d = SHIFT;
`ifdef PISO_PARITY_EN
                    par_d   = ^d;
`endif
                end
            end
            SHIFT: begin
                if (ser_ready) begin
                    sr_d = {sr_q[WIDTH-2:0], 1'b0};
                    if (cnt_last) begin
                        // Counter is left at zero so the next load starts clean.
                        cnt_clr = 1'b1;
`ifdef PISO_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = IDLE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                if (ser_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            done_q  <= done_d;
`ifdef PISO_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Outputs decode registered state only; no input reaches an output combinationally.
    always_comb begin
        sout = 1'b0;
        case (state_q)
            SHIFT:   sout = sr_q[WIDTH-1];
`ifdef PISO_PARITY_EN
            PARITY:  sout = par_q;
`endif
            default: sout = 1'b0;
        endcase
    end

    assign load_ready = (state_q == IDLE);
    assign sout_valid = (state_q != IDLE);
    assign done       = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed-vector bench for piso_serializer (WIDTH=8), both parity build options.
module tb_piso_serializer;

    logic       clk;
    logic       reset_n;
    logic [7:0] d;
    logic       load_valid;
    logic       load_ready;
    logic       ser_ready;
    logic       sout;
    logic       sout_valid;
    logic       done;

    int n_vec;
    int n_err;
    int cyc;
    int done_seen;

    piso_serializer #(
        .WIDTH (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .d          (d),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .ser_ready  (ser_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_seen++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Called in the first SHIFT cycle with ser_ready high; returns in the done cycle.
    task automatic run_word(input logic [7:0] w, input logic p, input string tag);
        for (int k = 0; k < 8; k++) begin
            chk({tag, " bit"}, {31'd0, sout}, {31'd0, w[7-k]});
            chk({tag, " valid"}, {31'd0, sout_valid}, 32'd1);
            chk({tag, " done_low"}, {31'd0, done}, 32'd0);
            chk({tag, " ready_low"}, {31'd0, load_ready}, 32'd0);
            step();
        end
`ifdef PISO_PARITY_EN
        chk({tag, " parity"}, {31'd0, sout}, {31'd0, p});
        chk({tag, " parity_valid"}, {31'd0, sout_valid}, 32'd1);
        chk({tag, " parity_done_low"}, {31'd0, done}, 32'd0);
        step();
`else
        if (p !== 1'b0 && p !== 1'b1) $display("bad parity argument for %s", tag);
`endif
        chk({tag, " done"}, {31'd0, done}, 32'd1);
        chk({tag, " done_ready"}, {31'd0, load_ready}, 32'd1);
        chk({tag, " done_valid"}, {31'd0, sout_valid}, 32'd0);
    endtask

    initial begin
        logic [7:0] w;
        int         idx;
        int         base;
        int         dbase;

        n_vec      = 0;
        n_err      = 0;
        cyc        = 0;
        done_seen  = 0;
        reset_n    = 1'b0;
        d          = 8'h00;
        load_valid = 1'b0;
        ser_ready  = 1'b0;

        #12;
        chk("rst load_ready", {31'd0, load_ready}, 32'd1);
        chk("rst sout", {31'd0, sout}, 32'd0);
        chk("rst sout_valid", {31'd0, sout_valid}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // A5: 1,0,1,0,0,1,0,1 then done; even parity 0
        load_valid = 1'b1;
        d          = 8'hA5;
        ser_ready  = 1'b1;
        step();
        load_valid = 1'b0;
        run_word(8'hA5, 1'b0, "a5");
        step();
        chk("a5 post done", {31'd0, done}, 32'd0);

        // 07: three ones, parity 1
        load_valid = 1'b1;
        d          = 8'h07;
        step();
        load_valid = 1'b0;
        run_word(8'h07, 1'b1, "07");
        step();

        // 3C with ser_ready low for three edges while bit 2 is on sout
        load_valid = 1'b1;
        d          = 8'h3C;
        step();
        load_valid = 1'b0;
        w          = 8'h3C;
        idx        = 0;
        for (int c = 0; c < 11; c++) begin
            chk("3c bit", {31'd0, sout}, {31'd0, w[7-idx]});
            chk("3c valid", {31'd0, sout_valid}, 32'd1);
            chk("3c done_low", {31'd0, done}, 32'd0);
            ser_ready = !(c >= 2 && c <= 4);
            step();
            if (ser_ready) idx++;
        end
        ser_ready = 1'b1;
`ifdef PISO_PARITY_EN
        chk("3c parity", {31'd0, sout}, 32'd0);
        step();
`endif
        chk("3c done", {31'd0, done}, 32'd1);
        chk("3c done_valid", {31'd0, sout_valid}, 32'd0);
        step();

        // 00 with load_valid held and d switched to FF mid-word
        load_valid = 1'b1;
        d          = 8'h00;
        step();
        d = 8'hFF;
        run_word(8'h00, 1'b0, "00");
        step();
        load_valid = 1'b0;
        run_word(8'hFF, 1'b0, "ff");
        step();
        chk("ff post done", {31'd0, done}, 32'd0);

        // Back-to-back 81 then 18
        load_valid = 1'b1;
        d          = 8'h81;
        base       = cyc;
        dbase      = done_seen;
        step();
        d = 8'h18;
        run_word(8'h81, 1'b0, "81");
        step();
        load_valid = 1'b0;
        run_word(8'h18, 1'b0, "18");
`ifdef PISO_PARITY_EN
        chk("b2b cycles", cyc - base, 32'd20);
`else
        chk("b2b cycles", cyc - base, 32'd18);
`endif
        step();
        chk("b2b done pulses", done_seen - dbase, 32'd2);
        chk("b2b post done", {31'd0, done}, 32'd0);

        // C3 aborted by async reset after bit 3
        load_valid = 1'b1;
        d          = 8'hC3;
        step();
        load_valid = 1'b0;
        w          = 8'hC3;
        for (int k = 0; k < 4; k++) begin
            chk("c3 bit", {31'd0, sout}, {31'd0, w[7-k]});
            step();
        end
        chk("c3 bit4 pre-reset", {31'd0, sout}, 32'd0);
        chk("c3 valid pre-reset", {31'd0, sout_valid}, 32'd1);
        dbase = done_seen;
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort sout_valid", {31'd0, sout_valid}, 32'd0);
        chk("abort load_ready", {31'd0, load_ready}, 32'd1);
        chk("abort sout", {31'd0, sout}, 32'd0);
        chk("abort done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("post-abort load_ready", {31'd0, load_ready}, 32'd1);
            chk("post-abort valid", {31'd0, sout_valid}, 32'd0);
        end
        chk("post-abort no done", done_seen - dbase, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
